// File: rtl/parser_arb_pkg.sv
// Shared types and width helpers for the parser ingress arbiter.
package parser_arb_pkg;

  localparam int unsigned ARB_BUS_WIDTH_B = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_XFER,
    ARB_GAP
  } arb_state_e;

  // Width of the last-word byte count; never narrower than one bit.
  function automatic int unsigned lb_w(input int unsigned bus_width_b);
    return (bus_width_b < 2) ? 1 : $clog2(bus_width_b);
  endfunction

  // Width of the gap down-counter, which holds GAP_CYC-1 at most.
  function automatic int unsigned gap_w(input int unsigned gap_cyc);
    return (gap_cyc < 2) ? 1 : $clog2(gap_cyc);
  endfunction

  localparam int unsigned ARB_LB_W = lb_w(ARB_BUS_WIDTH_B);

  typedef struct packed {
    logic [ARB_BUS_WIDTH_B*8-1:0] data;
    logic                         sop;
    logic                         eop;
    logic [ARB_LB_W-1:0]          lb;
  } arb_word_t;

endpackage

// File: rtl/parser_ingress_arb_rr_arbiter.sv
// Combinational round-robin pick starting at the pointer; pointer is held by the parent.
module rr_arbiter
  import parser_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] ptr_i,
  output logic [NUM_SRC-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx_o,
  output logic [$clog2(NUM_SRC)-1:0] ptr_nxt_o,
  output logic                       any_o
);

  localparam int unsigned PW = $clog2(NUM_SRC);

  // First requester found walking up from the pointer wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    ptr_nxt_o = ptr_i;
    any_o     = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      int unsigned     idx;
      logic [PW-1:0]   idx_p;
      idx   = (32'(ptr_i) + i) % NUM_SRC;
      idx_p = PW'(idx);
      if (!any_o && req_i[idx_p]) begin
        any_o            = 1'b1;
        gnt_oh_o[idx_p]  = 1'b1;
        gnt_idx_o        = idx_p;
        ptr_nxt_o        = PW'((idx + 1) % NUM_SRC);
      end
    end
  end

endmodule

// File: rtl/parser_ingress_arb.sv
// Packet-granular round-robin arbiter feeding one packet parser.
// Optional per-source packet and global underrun counters: define PARSER_ARB_STATS_EN.
module parser_ingress_arb
  import parser_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned BUS_WIDTH_B = ARB_BUS_WIDTH_B,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned LB_W        = lb_w(BUS_WIDTH_B)
) (
  input  logic                            CLK,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_valid_i,
  input  logic [NUM_SRC*BUS_WIDTH_B*8-1:0] src_data_i,
  input  logic [NUM_SRC-1:0]              src_sop_i,
  input  logic [NUM_SRC-1:0]              src_eop_i,
  input  logic [NUM_SRC*LB_W-1:0]         src_lb_i,
  output logic [NUM_SRC-1:0]              src_ready_o,
  output logic [BUS_WIDTH_B*8-1:0]        bus_o,
  output logic                            sop_o,
  output logic                            valid_o,
  output logic                            eop_o,
  output logic [LB_W-1:0]                 lb_o,
  output logic [$clog2(NUM_SRC)-1:0]      grant_id_o,
  output logic                            underrun_o
`ifdef PARSER_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]           pkt_cnt_o,
  output logic [31:0]                     urun_cnt_o
`endif
);

  localparam int unsigned DW = BUS_WIDTH_B * 8;
  localparam int unsigned PW = $clog2(NUM_SRC);
  localparam int unsigned GW = gap_w(GAP_CYC);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [PW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               in_pkt_q, in_pkt_d;
  logic               stall_q, stall_d;
  arb_word_t          word_q, word_d;
  logic               valid_q, valid_d;
  logic               underrun_q, underrun_d;
  logic [NUM_SRC-1:0] ready_q, ready_d;

  logic [NUM_SRC-1:0] arb_oh;
  logic [PW-1:0]      arb_idx, arb_ptr_nxt;
  logic               arb_any;

  logic               g_valid, g_sop, g_eop;
  logic [DW-1:0]      g_data;
  logic [LB_W-1:0]    g_lb;
  logic               eop_xfer;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i     (src_valid_i & src_sop_i),
    .ptr_i     (rr_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx),
    .ptr_nxt_o (arb_ptr_nxt),
    .any_o     (arb_any)
  );

  // Select the word presented by the current grant owner.
  always_comb begin
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    g_data  = '0;
    g_lb    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == PW'(i)) begin
        g_valid = src_valid_i[i];
        g_sop   = src_sop_i[i];
        g_eop   = src_eop_i[i];
        g_data  = src_data_i[i*DW +: DW];
        g_lb    = src_lb_i[i*LB_W +: LB_W];
      end
    end
  end

  assign eop_xfer = (state_q == ARB_XFER) && g_valid && g_eop;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    gap_d      = gap_q;
    in_pkt_d   = in_pkt_q;
    stall_d    = stall_q;
    ready_d    = '0;
    valid_d    = 1'b0;
    word_d     = '0;
    underrun_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (arb_any) begin
          state_d  = ARB_XFER;
          grant_d  = arb_idx;
          rr_d     = arb_ptr_nxt;
          ready_d  = arb_oh;
          in_pkt_d = 1'b0;
          stall_d  = 1'b0;
        end
      end
      ARB_XFER: begin
        ready_d = ready_q;
        if (g_valid) begin
          valid_d     = 1'b1;
          word_d.data = g_data;
          word_d.sop  = g_sop;
          word_d.eop  = g_eop;
          word_d.lb   = g_eop ? g_lb : '0;
          stall_d     = 1'b0;
          in_pkt_d    = 1'b1;
          // A sop arriving mid-packet restarts the packet and is flagged.
          if (g_sop && in_pkt_q) underrun_d = 1'b1;
          if (g_eop) begin
            ready_d  = '0;
            in_pkt_d = 1'b0;
            if (GAP_CYC == 0) begin
              state_d = ARB_IDLE;
            end else begin
              state_d = ARB_GAP;
              gap_d   = GW'(GAP_CYC - 1);
            end
          end
        end else if (in_pkt_q && !stall_q) begin
          underrun_d = 1'b1;
          stall_d    = 1'b1;
        end
      end
      ARB_GAP: begin
        // The final gap cycle arbitrates so the next sop lands exactly GAP_CYC idle cycles later.
        if (gap_q == '0) begin
          state_d = ARB_IDLE;
          if (arb_any) begin
            state_d  = ARB_XFER;
            grant_d  = arb_idx;
            rr_d     = arb_ptr_nxt;
            ready_d  = arb_oh;
            in_pkt_d = 1'b0;
            stall_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_q       <= '0;
      grant_q    <= '0;
      gap_q      <= '0;
      in_pkt_q   <= 1'b0;
      stall_q    <= 1'b0;
      ready_q    <= '0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      gap_q      <= gap_d;
      in_pkt_q   <= in_pkt_d;
      stall_q    <= stall_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
      underrun_q <= underrun_d;
    end
  end

  assign src_ready_o = ready_q;
  assign bus_o       = word_q.data;
  assign sop_o       = word_q.sop;
  assign valid_o     = valid_q;
  assign eop_o       = word_q.eop;
  assign lb_o        = word_q.lb;
  assign grant_id_o  = grant_q;
  assign underrun_o  = underrun_q;

`ifdef PARSER_ARB_STATS_EN
  logic [NUM_SRC-1:0][31:0] pkt_cnt_q;
  logic [31:0]              urun_cnt_q;

  // Saturating packet (per eop transfer) and underrun counters.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      urun_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (eop_xfer && grant_q == PW'(i) && pkt_cnt_q[i] != '1) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end
      end
      if (underrun_d && urun_cnt_q != '1) urun_cnt_q <= urun_cnt_q + 32'd1;
    end
  end

  assign pkt_cnt_o  = pkt_cnt_q;
  assign urun_cnt_o = urun_cnt_q;
`else
  logic unused_eop_xfer;
  assign unused_eop_xfer = eop_xfer;
`endif

endmodule

// File: doc/parser_ingress_arb.md
Name: parser_ingress_arb

Overview:
- Packet-granular round-robin arbiter that shares one packet-parser instance (PacketParserN-series) between NUM_SRC word-stream sources.
- Locks a grant for a whole packet and forwards it word by word onto the parser bus.
- Generates the parser's start_of_packet pulse and last-word byte count.
- Enforces a minimum idle gap between packets; sits directly upstream of the parser.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- BUS_WIDTH_B, 4, bus width in bytes (matches parser `BUS_WIDTH_B).
- GAP_CYC, 2, idle cycles forced after each eop before the next sop (0..15).
- LB_W, $clog2(BUS_WIDTH_B), width of the last-word byte count.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- src_valid_i  in  NUM_SRC  per-source word valid.
- src_data_i  in  NUM_SRC*BUS_WIDTH_B*8  per-source word; byte 0 in the MS byte.
- src_sop_i  in  NUM_SRC  first word of packet.
- src_eop_i  in  NUM_SRC  last word of packet.
- src_lb_i  in  NUM_SRC*LB_W  valid bytes in the eop word; 0 = full word.
- src_ready_o  out  NUM_SRC  word accepted this cycle (valid & ready = transfer).
- bus_o  out  BUS_WIDTH_B*8  parser bus.
- sop_o  out  1  to parser start_of_packet_i.
- valid_o  out  1  bus_o carries a packet word.
- eop_o  out  1  last word of packet.
- lb_o  out  LB_W  byte count qualifying eop_o; zero otherwise.
- grant_id_o  out  $clog2(NUM_SRC)  source owning the current packet.
- underrun_o  out  1  one-cycle pulse on a mid-packet stall by the granted source.

Behaviour:
- Reset (sync, active-high): state=IDLE, rr pointer=0; all outputs 0, bus_o=0.
- Outputs are registered: a word accepted in cycle t appears on bus_o/valid_o in t+1, giving 1-cycle latency.
- IDLE: waits for any src_valid_i & src_sop_i.
  - Round-robin pick, starting at rr pointer, among sources presenting valid & sop; same cycle goes to XFER.
  - rr pointer becomes winner+1 (mod NUM_SRC).
  - A source presenting valid without sop while idle is held off (ready=0); it is never granted on a non-sop word.
- XFER: src_ready_o[grant]=1 only; all other ready bits are 0.
  - Each valid word is forwarded; sop_o=1 on the first forwarded word only.
  - eop word: eop_o=1, lb_o=src_lb, then go to GAP (or IDLE if GAP_CYC=0).
  - Granted valid=0 mid-packet: underrun_o pulses once per stall episode; valid_o=0 and bus_o=0 during the stall; grant is held.
  - sop received while already mid-packet (a nested sop): treated as a new packet start. sop_o is re-asserted on that word and underrun_o pulses.
- GAP: counts GAP_CYC cycles with all ready=0 and valid_o=0, then goes to IDLE. Arbitration is evaluated in the last GAP cycle, so back-to-back sops are exactly GAP_CYC idle cycles apart.
- Single-word packet (sop & eop in the same word): sop_o=eop_o=1 on one cycle.
- lb_o values ≥ BUS_WIDTH_B are illegal; they are forwarded unchanged and flagged by a bench assertion.
- reset asserted mid-packet: packet is dropped, outputs clear on the next edge, and no eop is emitted.

Optional Feature:
- Macro PARSER_ARB_STATS_EN.
- Defined: adds per-source 32-bit packet counters and a 32-bit global underrun counter.
  - Packet counter increments on eop transfer; all counters saturate at all-ones and clear on reset.
  - Exposed as pkt_cnt_o (NUM_SRC*32) and urun_cnt_o (32).
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package parser_arb_pkg: state enum (ARB_IDLE, ARB_XFER, ARB_GAP); a word struct (data, sop, eop, lb); LB_W and GAP counter width functions.
- Sub-module rr_arbiter (NUM_SRC requests in; one-hot grant and pointer-update out; purely combinational pick with a registered pointer in the parent).

Test Plan:
- Single source 0, 13-byte packet (BUS_WIDTH_B=4) → 4 bus words 1 cycle after each accept; sop_o on word 1; eop_o on word 4 with lb_o=1; grant_id_o=0.
- Sources 0..3 all request at the same time, GAP_CYC=2 → grants in order 0,1,2,3; exactly 2 idle cycles between each eop and the next sop; ready only to the grant owner.
- Source 1 drops valid for 3 cycles mid-packet → one underrun_o pulse; valid_o=0 for 3 cycles; packet completes with correct data order.
- Source 2 sends a single-word packet with lb=0 → one cycle with sop_o=eop_o=valid_o=1 and lb_o=0.
- reset for 1 cycle mid-XFER on source 3 → next cycle all outputs 0; rr pointer=0; a new request from source 1 is granted normally.
- With PARSER_ARB_STATS_EN: 5 packets from source 0 and 2 underruns → pkt_cnt_o[0]=5, urun_cnt_o=2.
